valu_arbiter: RTL and testbench
===============================

VALU_ARBITER -- requirements
Module: valu_arbiter

Interface
REQ-001 SHALL have parameter N, default 18, lane width in bits.
REQ-002 SHALL have parameter V, default 3, lane count.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  [1:0]  per-requester command valid.
REQ-006 SHALL have port req_ready  output  [1:0]  per-requester command accepted.
REQ-007 SHALL have port req_op  input  [1:0][3:0]  per-requester ALU opcode.
REQ-008 SHALL have port req_a  input  [1:0][V-1:0][N-1:0]  per-requester operand vector A.
REQ-009 SHALL have port req_b  input  [1:0][V-1:0][N-1:0]  per-requester operand vector B.
REQ-010 SHALL have port resp_valid  output  [1:0]  response valid, one-hot to the owning requester.
REQ-011 SHALL have port resp_ready  input  [1:0]  per-requester response accept.
REQ-012 SHALL have port resp_result  output  [V-1:0][N-1:0]  shared response result bus.
REQ-013 SHALL have port resp_flags  output  [3:0]  {overflow, carry, zero, negative} from the vector ALU.
REQ-014 SHALL have port resp_err  output  1  opcode rejected.
REQ-015 SHALL have port alu_a, alu_b  output  [V-1:0][N-1:0]  registered operands to the vector ALU.
REQ-016 SHALL have port alu_op  output  [3:0]  registered opcode to the vector ALU.
REQ-017 SHALL have port alu_result  input  [V-1:0][N-1:0]  combinational ALU result.
REQ-018 SHALL have port alu_flags  input  [3:0]  combinational ALU flags.
REQ-019 SHALL have port op_count  output  [1:0][15:0]  per-requester completed-operation counters.

Function
REQ-020 SHALL implement FSM states IDLE, EXEC, CAPT, RESP.
REQ-021 SHALL assert req_ready only in IDLE, to the granted requester only, and at most one bit at a time.
REQ-022 SHALL grant round-robin: a lone requester wins; when both are valid, the requester not granted last wins; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-023 SHALL, on accept in IDLE, register op/A/B into alu_op/alu_a/alu_b, record the owner, and go to EXEC.
REQ-024 SHALL go EXEC->CAPT unconditionally, giving the ALU one full cycle on stable operands.
REQ-025 SHALL, in CAPT, capture alu_result and alu_flags, then go to RESP.
REQ-026 SHALL make accept-to-resp_valid latency exactly 3 cycles.
REQ-027 SHALL treat opcodes 4'b0000-4'b0101 as legal; 4'b0101 (horizontal lane sum into lane 0) passes through the ALU unmodified.
REQ-028 SHALL handle an illegal opcode (>4'b0101) as follows: alu_op stays unchanged, resp_result=0, resp_flags=0, resp_err=1, same 3-cycle latency.
REQ-029 SHALL, in RESP, hold resp_valid[owner]=1 and resp_result/flags/err stable until resp_ready[owner]=1, then return to IDLE.
REQ-030 SHALL ignore resp_ready of the non-owner.
REQ-031 SHALL, on each completed response handshake, increment op_count[owner], saturating at 16'hFFFF; error responses also count.
REQ-032 SHALL keep alu_a/alu_b/alu_op holding their last values outside accept cycles, so no spurious ALU toggling occurs.
REQ-033 SHALL not accept a new command in the RESP handshake cycle; the next accept is no earlier than the following IDLE cycle.
REQ-034 SHALL ignore changes to req_valid while not in IDLE; requests are not queued.

Reset
REQ-035 SHALL, when rst_n=0 on a clock edge, force: state=IDLE, req_ready=0, resp_valid=0, resp_result=0, resp_flags=0, resp_err=0, alu_a=0, alu_b=0, alu_op=0, op_count=0, last-grant=1.
REQ-036 SHALL abort any in-flight operation on reset mid-operation, with no response issued and no counter change.

Structure
REQ-037 SHALL take N, V, the opcode enum (including OP_HSUM=4'b0101 and OP_LAST_LEGAL) and the state enum from shared package valu_pkg.
REQ-038 SHALL place arbitration in sub-module valu_rr_arb2 (inputs: valid[1:0], last grant, enable; output: one-hot grant).

Verification
REQ-039 SHALL cover: req0 alone, op=0000 (add), A={1,2,3}, B={4,5,6} -> resp_valid[0] 3 cycles after accept, resp_result={5,7,9}, resp_err=0, op_count[0]=1.
REQ-040 SHALL cover: both valid continuously, 4 commands -> grants alternate 0,1,0,1; each responds to its owner only.
REQ-041 SHALL cover: req1 op=4'b1010 -> resp_err=1, resp_result=0, resp_flags=0, alu_op unchanged.
REQ-042 SHALL cover: resp_ready held low for 5 cycles -> resp_valid and data stable, req_ready=0 throughout.
REQ-043 SHALL cover: rst_n=0 during CAPT -> next cycle all outputs at reset values, no response, counters 0.
REQ-044 SHALL cover: op_count[0] preloaded to 16'hFFFE, then 3 completions -> count saturates at 16'hFFFF.

Source files
------------

// File: rtl/valu_pkg.sv
// Shared types for the vector-ALU arbiter: lane geometry, opcodes, FSM states.
package valu_pkg;

    localparam int N = 18;
    localparam int V = 3;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_HSUM = 4'b0101
    } op_e;

    localparam logic [3:0] OP_LAST_LEGAL = OP_HSUM;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/valu_rr_arb2.sv
// Two-way round-robin arbiter; grant is one-hot and zero when disabled.
module valu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/valu_arbiter.sv
// Arbitrates two requesters onto one external vector ALU with a fixed
// accept-to-response latency of three cycles.
module valu_arbiter #(
    parameter int N = valu_pkg::N,
    parameter int V = valu_pkg::V
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][3:0]            req_op,
    input  logic [1:0][V-1:0][N-1:0]   req_a,
    input  logic [1:0][V-1:0][N-1:0]   req_b,
    output logic [1:0]                 resp_valid,
    input  logic [1:0]                 resp_ready,
    output logic [V-1:0][N-1:0]        resp_result,
    output logic [3:0]                 resp_flags,
    output logic                       resp_err,
    output logic [V-1:0][N-1:0]        alu_a,
    output logic [V-1:0][N-1:0]        alu_b,
    output logic [3:0]                 alu_op,
    input  logic [V-1:0][N-1:0]        alu_result,
    input  logic [3:0]                 alu_flags,
    output logic [1:0][15:0]           op_count
);

    import valu_pkg::*;

    typedef logic [V-1:0][N-1:0] vec_t;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            ill_q, ill_d;
    logic [3:0]      alu_op_q, alu_op_d;
    vec_t            alu_a_q, alu_a_d;
    vec_t            alu_b_q, alu_b_d;
    vec_t            res_q, res_d;
    logic [3:0]      flags_q, flags_d;
    logic            err_q, err_d;
    logic [1:0]      resp_valid_q, resp_valid_d;
    logic [1:0][15:0] op_cnt_q, op_cnt_d;

    logic [1:0]      grant;
    logic            accept;
    logic            gidx;
    logic            done;

    // Gating with rst_n keeps req_ready low while reset is held.
    valu_rr_arb2 u_arb (
        .valid (req_valid),
        .last  (last_q),
        .en    ((state_q == IDLE) && rst_n),
        .grant (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign gidx      = grant[1];
    assign done      = (state_q == RESP) && resp_ready[owner_q];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        ill_d        = ill_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_d        = res_q;
        flags_d      = flags_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        op_cnt_d     = op_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gidx;
                    last_d  = gidx;
                    alu_a_d = req_a[gidx];
                    alu_b_d = req_b[gidx];
                    ill_d   = !op_legal(req_op[gidx]);
                    if (op_legal(req_op[gidx]))
                        alu_op_d = req_op[gidx];
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                if (ill_q) begin
                    res_d   = '0;
                    flags_d = 4'h0;
                    err_d   = 1'b1;
                end else begin
                    res_d   = alu_result;
                    flags_d = alu_flags;
                    err_d   = 1'b0;
                end
                resp_valid_d = 2'b01 << owner_q;
                state_d      = RESP;
            end
            RESP: begin
                if (done) begin
                    resp_valid_d = 2'b00;
                    if (op_cnt_q[owner_q] != 16'hFFFF)
                        op_cnt_d[owner_q] = op_cnt_q[owner_q] + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            ill_q        <= 1'b0;
            alu_op_q     <= 4'h0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_q        <= '0;
            flags_q      <= 4'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            op_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            ill_q        <= ill_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_q        <= res_d;
            flags_q      <= flags_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            op_cnt_q     <= op_cnt_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_result = res_q;
    assign resp_flags  = flags_q;
    assign resp_err    = err_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign op_count    = op_cnt_q;

endmodule

// File: tb/tb_valu_arbiter.sv
// Directed bench for valu_arbiter with a small lane-wise ALU attached.
module tb_valu_arbiter;

    import valu_pkg::*;

    typedef logic [V-1:0][N-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][3:0]  req_op;
    logic [1:0][V-1:0][N-1:0] req_a;
    logic [1:0][V-1:0][N-1:0] req_b;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    vec_t             resp_result;
    logic [3:0]       resp_flags;
    logic             resp_err;
    vec_t             alu_a;
    vec_t             alu_b;
    logic [3:0]       alu_op;
    vec_t             alu_result;
    logic [3:0]       alu_flags;
    logic [1:0][15:0] op_count;

    int checks = 0;
    int errors = 0;

    valu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    // External ALU: lane-wise ops, HSUM sums A lanes into lane 0.
    always_comb begin
        alu_result = '0;
        for (int i = 0; i < V; i++) begin
            case (alu_op)
                OP_ADD:  alu_result[i] = alu_a[i] + alu_b[i];
                OP_SUB:  alu_result[i] = alu_a[i] - alu_b[i];
                OP_AND:  alu_result[i] = alu_a[i] & alu_b[i];
                OP_OR:   alu_result[i] = alu_a[i] | alu_b[i];
                OP_XOR:  alu_result[i] = alu_a[i] ^ alu_b[i];
                default: alu_result[i] = '0;
            endcase
        end
        if (alu_op == OP_HSUM) begin
            alu_result    = '0;
            alu_result[0] = alu_a[0] + alu_a[1] + alu_a[2];
        end
        alu_flags = {2'b00, alu_result == '0, alu_result[0][N-1]};
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input logic [3:0] op, input vec_t a,
                        input vec_t b, input int hold, input vec_t er,
                        input logic [3:0] ef, input logic ee,
                        input string tag);
        int n;
        int lat;
        logic [1:0] m;
        m = (r == 0) ? 2'b01 : 2'b10;
        req_op[r]    = op;
        req_a[r]     = a;
        req_b[r]     = b;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".ready"}, 64'(req_ready), 64'(m));
        tick();
        req_valid[r] = 1'b0;
        lat = 1;
        while (resp_valid == 2'b00 && lat < 10) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'd3);
        chk({tag, ".rvalid"}, 64'(resp_valid), 64'(m));
        chk({tag, ".res"}, 64'(resp_result), 64'(er));
        chk({tag, ".flags"}, 64'(resp_flags), 64'(ef));
        chk({tag, ".err"}, 64'(resp_err), 64'(ee));
        for (int i = 0; i < hold; i++) begin
            resp_ready = ~m;
            tick();
            chk({tag, ".hold_v"}, 64'(resp_valid), 64'(m));
            chk({tag, ".hold_r"}, 64'(resp_result), 64'(er));
            chk({tag, ".hold_rdy"}, 64'(req_ready), 64'd0);
        end
        resp_ready = m;
        tick();
        resp_ready = 2'b00;
        chk({tag, ".drop"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int lat;
        logic [1:0] m;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 2'b00;
        repeat (3) tick();

        chk("rst.ready", 64'(req_ready), 64'd0);
        chk("rst.rvalid", 64'(resp_valid), 64'd0);
        chk("rst.res", 64'(resp_result), 64'd0);
        chk("rst.flags", 64'(resp_flags), 64'd0);
        chk("rst.err", 64'(resp_err), 64'd0);
        chk("rst.alu_a", 64'(alu_a), 64'd0);
        chk("rst.alu_b", 64'(alu_b), 64'd0);
        chk("rst.alu_op", 64'(alu_op), 64'd0);
        chk("rst.cnt", 64'(op_count), 64'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        tick();

        send(0, OP_ADD, {18'd1, 18'd2, 18'd3}, {18'd4, 18'd5, 18'd6}, 0,
             {18'd5, 18'd7, 18'd9}, 4'h0, 1'b0, "add");
        chk("add.cnt0", 64'(op_count[0]), 64'd1);
        chk("add.aluop", 64'(alu_op), 64'(OP_ADD));

        send(0, OP_SUB, {18'd30, 18'd20, 18'd10}, {18'd7, 18'd5, 18'd3}, 5,
             {18'd23, 18'd15, 18'd7}, 4'h0, 1'b0, "stall");
        chk("stall.cnt0", 64'(op_count[0]), 64'd2);

        send(1, OP_XOR, {18'h0F, 18'hF0, 18'hFF}, {18'hFF, 18'hFF, 18'hFF}, 0,
             {18'hF0, 18'h0F, 18'h00}, 4'h0, 1'b0, "xor");

        send(1, 4'b1010, {18'd1, 18'd1, 18'd1}, {18'd1, 18'd1, 18'd1}, 0,
             '0, 4'h0, 1'b1, "ill");
        chk("ill.aluop", 64'(alu_op), 64'(OP_XOR));
        chk("ill.cnt1", 64'(op_count[1]), 64'd2);

        send(0, OP_HSUM, {18'd1, 18'd2, 18'd3}, '0, 0,
             {18'd0, 18'd0, 18'd6}, 4'h0, 1'b0, "hsum");
        chk("hsum.cnt0", 64'(op_count[0]), 64'd3);

        req_op[0]    = OP_ADD;
        req_a[0]     = {18'd1, 18'd1, 18'd1};
        req_b[0]     = {18'd1, 18'd1, 18'd1};
        req_valid[0] = 1'b1;
        #1;
        chk("abort.ready", 64'(req_ready), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort.rvalid", 64'(resp_valid), 64'd0);
        chk("abort.res", 64'(resp_result), 64'd0);
        chk("abort.aluop", 64'(alu_op), 64'd0);
        chk("abort.alu_a", 64'(alu_a), 64'd0);
        chk("abort.cnt", 64'(op_count), 64'd0);
        chk("abort.ready0", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort.noresp", 64'(resp_valid), 64'd0);

        req_op[0] = OP_OR;
        req_a[0]  = {18'hF0, 18'hF0, 18'hF0};
        req_b[0]  = {18'h0F, 18'h0F, 18'h0F};
        req_op[1] = OP_SUB;
        req_a[1]  = {18'd0, 18'd0, 18'd0};
        req_b[1]  = {18'd0, 18'd0, 18'd1};
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            m = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            chk("rr.grant", 64'(req_ready), 64'(m));
            tick();
            lat = 1;
            while (resp_valid == 2'b00 && lat < 10) begin
                tick();
                lat++;
            end
            chk("rr.lat", 64'(lat), 64'd3);
            chk("rr.owner", 64'(resp_valid), 64'(m));
            if (k % 2 == 0) begin
                chk("rr.res0", 64'(resp_result),
                    64'({18'hFF, 18'hFF, 18'hFF}));
                chk("rr.flg0", 64'(resp_flags), 64'h0);
            end else begin
                chk("rr.res1", 64'(resp_result),
                    64'({18'd0, 18'd0, 18'h3FFFF}));
                chk("rr.flg1", 64'(resp_flags), 64'h1);
            end
            resp_ready = 2'b11;
            tick();
            resp_ready = 2'b00;
        end
        req_valid = 2'b00;
        chk("rr.cnt", 64'(op_count), 64'({16'd2, 16'd2}));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        force dut.op_cnt_q = 32'h0000_FFFE;
        @(posedge clk);
        #1;
        release dut.op_cnt_q;
        tick();
        chk("sat.pre", 64'(op_count[0]), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            send(0, OP_ADD, {18'd0, 18'd0, 18'd1}, {18'd0, 18'd0, 18'd1}, 0,
                 {18'd0, 18'd0, 18'd2}, 4'h0, 1'b0, "sat");
            chk("sat.cnt0", 64'(op_count[0]), 64'hFFFF);
        end
        chk("sat.cnt1", 64'(op_count[1]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
